hamming_secded_encoder_stream: RTL
==================================

Name: hamming_secded_encoder_stream

Overview:
- Parametrised streaming Hamming encoder; next generation of the fixed [7,4] encoder.
- Generic data width, optional overall-parity bit (SECDED), valid/ready handshake with backpressure, built-in error injection, and word/injection counters.
- Sits between a data producer and the storage or link path; its output feeds the matching decoder and the verification error-injection flows.

Parameters:
- DATA_W, 4, data bits per word (1..64).
- SECDED, 1, 1 = append overall parity bit; 0 = plain Hamming.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  encoder can accept a word.
- in_data  in  DATA_W  data word.
- inj_en  in  1  flip one codeword bit for this beat.
- inj_pos  in  8  codeword bit index to flip.
- out_valid  out  1  codeword valid.
- out_ready  in  1  downstream accepts the codeword.
- out_code  out  CODE_W  codeword.
- word_cnt  out  CNT_W  codewords accepted downstream.
- inj_cnt  out  CNT_W  codewords emitted with an injected flip.

Behaviour:
- Clock and reset are fixed: one clock `clk`; `rst` is asynchronous and active-high.
- Widths:
  - PAR_W = smallest r with 2^r >= DATA_W + r + 1 (DATA_W=4 gives 3; 11 gives 4; 26 gives 5; 57 gives 6).
  - CODE_W = DATA_W + PAR_W + SECDED.
- Position map:
  - Data bit d[k] occupies the k-th non-power-of-two position of the classic 1-based Hamming layout (positions 3, 5, 6, 7, 9, ...).
  - p[i] = XOR of all d[k] whose position has bit i set.
- Codeword layout: out_code = {pe (SECDED only), in_data, p[PAR_W-1:0]}. Systematic: data field unchanged.
- Overall parity: pe = XOR of all data and parity bits, computed before injection.
- Injection:
  - Applied when inj_en=1 and inj_pos < CODE_W: out_code[inj_pos] is inverted after encoding.
  - inj_pos >= CODE_W: no flip, and inj_cnt does not increment.
  - inj_en and inj_pos are sampled with the accepted input beat.
- Handshake:
  - Single registered output stage; in_ready = !out_valid || out_ready (combinational).
  - Input transfer occurs when in_valid && in_ready; codeword is presented the next cycle (latency 1).
  - Full throughput: one word per cycle while out_ready=1.
  - While out_valid && !out_ready, out_code holds stable and in_ready=0.
  - out_valid may not drop without a transfer.
- States (implicit in out_valid):
  - EMPTY -> FULL on input transfer.
  - FULL -> FULL on simultaneous output and input transfer.
  - FULL -> EMPTY on output transfer without input.
- Counters:
  - word_cnt increments on each output transfer.
  - inj_cnt increments on an output transfer whose word carried a valid injection.
  - Both saturate at all-ones; no wrap.
- Reset (any time, including mid-transfer):
  - out_valid=0 and out_code=0 immediately.
  - word_cnt=0 and inj_cnt=0.
  - The in-flight word is discarded.
  - in_ready=1 after reset.
- out_code is don't-care-stable (held) when out_valid=0 after first use; it is 0 after reset.

Decomposition:
- Package hamming_pkg holds:
  - functions par_w(DATA_W) and code_w(DATA_W, SECDED);
  - a function returning the Hamming position of data bit k;
  - the parity-compute function shared with the future decoder.
- One combinational sub-module, hamming_parity_gen (DATA_W in, PAR_W + SECDED out), instanced by the encoder and later reused by the decoder syndrome path.

Test Plan:
- DATA_W=4, SECDED=1, out_ready=1, in_data=4'b1011 -> out_code=8'h59 one cycle after accept; word_cnt=1.
- DATA_W=4, SECDED=1, in_data=4'hF then 4'h0 back-to-back -> out_code 8'hFF then 8'h00 on consecutive cycles; in_ready stays 1.
- DATA_W=4, SECDED=1, in_data=4'b1011, inj_en=1, inj_pos=0 -> out_code=8'h58, inj_cnt=1.
  - Same beat with inj_pos=9 -> 8'h59, inj_cnt unchanged.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0 and out_code stable.
  - Then out_ready=1 with a new in_valid word -> simultaneous transfer; no loss or duplicate.
  - word_cnt advances by 1 per output transfer.
- rst pulsed asynchronously mid-cycle while out_valid=1 -> out_valid, out_code and counters go to 0 without a clock edge; in_ready=1.
- Sweep DATA_W in {11, 26, 57}, SECDED in {0, 1}, random data -> reference-model parity match; CODE_W = 15/16, 31/32, 63/64; counters saturate at 2^CNT_W-1 with CNT_W=4.

Source files
------------

// File: rtl/hamming_secded_encoder_stream_pkg.sv
// Shared Hamming helpers: width arithmetic, data-bit position map and parity
// bit evaluation, used by the stream encoder and the matching decoder.
package hamming_pkg;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_PAR_W  = 7;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int par_w(input int data_w);
    int res;
    res = MAX_PAR_W;
    for (int r = MAX_PAR_W; r >= 1; r--) begin
      if ((1 << r) >= data_w + r + 1) res = r;
    end
    return res;
  endfunction

  function automatic int code_w(input int data_w, input int secded);
    return data_w + par_w(data_w) + secded;
  endfunction

  // 1-based Hamming position of data bit k, skipping every power of two.
  function automatic int data_pos(input int k);
    int pos;
    pos = k + 1;
    for (int r = 0; r < MAX_PAR_W; r++) begin
      if ((1 << r) <= pos) pos++;
    end
    return pos;
  endfunction

  // Parity bit idx: XOR of data bits whose position has bit idx set.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                      input int data_w, input int idx);
    logic acc;
    int   pos;
    acc = 1'b0;
    for (int k = 0; k < MAX_DATA_W; k++) begin
      pos = data_pos(k);
      if (k < data_w && pos[idx]) acc ^= data[k];
    end
    return acc;
  endfunction

endpackage

// File: rtl/hamming_secded_encoder_stream_if.sv
// Handshake bundle: producer-side input beat with injection control and the
// registered codeword output.
interface hamming_secded_encoder_stream_if
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CODE_W = code_w(DATA_W, 1)
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              inj_en;
  logic [7:0]        inj_pos;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;

  modport master (
    output in_valid, in_data, inj_en, inj_pos, out_ready,
    input  in_ready, out_valid, out_code
  );

  modport slave (
    input  in_valid, in_data, inj_en, inj_pos, out_ready,
    output in_ready, out_valid, out_code
  );
endinterface

// File: rtl/hamming_secded_encoder_stream_parity_gen.sv
// Combinational check-bit generator: Hamming parity plus optional overall parity
// in the top bit; reused by the decoder syndrome path.
module hamming_parity_gen
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int SECDED = 1,
  localparam int PAR_W = par_w(DATA_W)
) (
  input  logic [DATA_W-1:0]       data,
  output logic [PAR_W+SECDED-1:0] check
);
  logic [MAX_DATA_W-1:0] data_ext;
  logic [PAR_W-1:0]      par;

  assign data_ext = MAX_DATA_W'(data);

  for (genvar gi = 0; gi < PAR_W; gi++) begin : g_par
    assign par[gi] = parity_bit(data_ext, DATA_W, gi);
  end

  if (SECDED != 0) begin : g_secded
    assign check = {^{data, par}, par};
  end else begin : g_plain
    assign check = par;
  end
endmodule

// File: rtl/hamming_secded_encoder_stream.sv
// Streaming systematic Hamming/SECDED encoder with a single registered output
// stage, per-beat bit-flip injection and saturating statistics counters.
module hamming_secded_encoder_stream
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int SECDED = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  hamming_secded_encoder_stream_if.slave bus,
  output logic [CNT_W-1:0]         word_cnt,
  output logic [CNT_W-1:0]         inj_cnt
);
  localparam int PAR_W  = par_w(DATA_W);
  localparam int CODE_W = code_w(DATA_W, SECDED);

  stage_state_e        state_reg;
  stage_state_e        state_next;
  logic                out_valid;
  logic                in_fire;
  logic                out_fire;
  logic                inj_ok;
  logic [PAR_W+SECDED-1:0] check;
  logic [CODE_W-1:0]   enc_code;
  logic [CODE_W-1:0]   flip_mask;
  logic [CODE_W-1:0]   out_code_reg;
  logic                inj_flag_reg;
  logic [CNT_W-1:0]    word_cnt_reg;
  logic [CNT_W-1:0]    inj_cnt_reg;

  hamming_parity_gen #(
    .DATA_W(DATA_W),
    .SECDED(SECDED)
  ) u_parity_gen (
    .data  (bus.in_data),
    .check (check)
  );

  if (SECDED != 0) begin : g_code_secded
    assign enc_code = {check[PAR_W], bus.in_data, check[PAR_W-1:0]};
  end else begin : g_code_plain
    assign enc_code = {bus.in_data, check};
  end

  // Out-of-range positions neither flip a bit nor count as an injection.
  assign inj_ok = bus.inj_en && (bus.inj_pos < 8'(CODE_W));

  for (genvar gi = 0; gi < CODE_W; gi++) begin : g_flip
    assign flip_mask[gi] = inj_ok && (bus.inj_pos == 8'(gi));
  end

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: if (in_fire) state_next = ST_FULL;
      ST_FULL:  if (out_fire && !in_fire) state_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid    = (state_reg == ST_FULL);
    bus.out_valid = out_valid;
    bus.in_ready  = !out_valid || bus.out_ready;
    bus.out_code  = out_code_reg;
  end

  // Codeword is held when the stage empties; only a new accept replaces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_code_reg <= '0;
      inj_flag_reg <= 1'b0;
    end else if (in_fire) begin
      out_code_reg <= enc_code ^ flip_mask;
      inj_flag_reg <= inj_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_reg <= '0;
      inj_cnt_reg  <= '0;
    end else if (out_fire) begin
      if (word_cnt_reg != '1) word_cnt_reg <= word_cnt_reg + CNT_W'(1);
      if (inj_flag_reg && inj_cnt_reg != '1) inj_cnt_reg <= inj_cnt_reg + CNT_W'(1);
    end
  end

  assign word_cnt = word_cnt_reg;
  assign inj_cnt  = inj_cnt_reg;
endmodule
